alu_exec: RTL

- Execute stage directly downstream of the 16x32 register file.
- Captures the two read operands (register file Op1/Op2) plus an opcode and destination select.
- Computes single-cycle ALU ops, or iterative multiply/divide through an FSM.
- Returns the result to the register file write port (Ip1/sel_i1/WR), with status flags.

---
 rtl/alu_exec.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// alu_exec: execute stage between register file read and write ports.
// Define ALU_DIV_EN to build the iterative divider (opcode C).
`timescale 1ns/1ps
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SELW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  input  logic [SELW-1:0]  sel_d,
  output logic [WIDTH-1:0] Res,
  output logic [SELW-1:0]  sel_wr,
  output logic             WR,
  output logic             done,
  output logic             busy,
  output logic [5:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_PASS = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'hC;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SHW-1:0]     cnt_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     mul_sum;
`ifdef ALU_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_dif;
  logic               q_bit;
`endif

  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;
  logic             sc_ill;
  logic             sc_dz;
  logic             iter_op;
  logic             mul_sel;
  logic [WIDTH-1:0] it_res;
  logic             it_v;

  assign add_ext = {1'b0, Op1} + {1'b0, Op2};
  assign sub_ext = {1'b0, Op1} - {1'b0, Op2};
  assign shamt   = Op2[SHW-1:0];
  assign mul_sel = (opcode == OP_MUL);

  // Single-cycle results, flags and the multi-cycle request decode.
  always_comb begin
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_ill  = 1'b0;
    sc_dz   = 1'b0;
    iter_op = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        sc_res = add_ext[WIDTH-1:0];
        sc_c   = add_ext[WIDTH];
        sc_v   = (Op1[WIDTH-1] == Op2[WIDTH-1]) &&
                 (add_ext[WIDTH-1] != Op1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_ext[WIDTH-1:0];
        sc_c   = sub_ext[WIDTH];
        sc_v   = (Op1[WIDTH-1] != Op2[WIDTH-1]) &&
                 (sub_ext[WIDTH-1] != Op1[WIDTH-1]);
      end
      OP_AND:  sc_res = Op1 & Op2;
      OP_OR:   sc_res = Op1 | Op2;
      OP_XOR:  sc_res = Op1 ^ Op2;
      OP_NOT:  sc_res = ~Op1;
      OP_SHL:  sc_res = Op1 << shamt;
      OP_SHR:  sc_res = Op1 >> shamt;
      OP_SRA:  sc_res = $signed(Op1) >>> shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                         ($signed(Op1) < $signed(Op2))};
      OP_PASS: sc_res = Op1;
      OP_MUL:  iter_op = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (Op2 == '0) begin
          sc_res = '1;
          sc_dz  = 1'b1;
        end else begin
          iter_op = 1'b1;
        end
      end
`endif
      default: sc_ill = 1'b1;
    endcase
  end

  // One shift-add (or restoring-divide) step on the accumulator.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              (acc_q[0] ? {1'b0, m_q} : '0);
    acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_dif = rem_sh - {1'b0, m_q};
    q_bit   = ~rem_dif[WIDTH];
    if (div_q) begin
      acc_nxt = {(q_bit ? rem_dif[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], q_bit};
    end
`endif
  end

  assign it_res = acc_nxt[WIDTH-1:0];
`ifdef ALU_DIV_EN
  assign it_v = ~div_q & (|acc_nxt[2*WIDTH-1:WIDTH]);
`else
  assign it_v = |acc_nxt[2*WIDTH-1:WIDTH];
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = iter_op ? RUN : DONE;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; a stall freezes the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (EN) begin
      state_q <= state_d;
    end
  end

  // Operand capture, iteration and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      Res    <= '0;
      flags  <= '0;
      sel_wr <= '0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (EN) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sel_wr <= sel_d;
            if (iter_op) begin
              cnt_q <= SHW'(WIDTH-1);
              m_q   <= mul_sel ? Op1 : Op2;
              acc_q <= {{WIDTH{1'b0}}, (mul_sel ? Op2 : Op1)};
`ifdef ALU_DIV_EN
              div_q <= ~mul_sel;
`endif
            end else begin
              Res   <= sc_res;
              flags <= {sc_ill, sc_dz, sc_v, sc_c,
                        sc_res[WIDTH-1], ~|sc_res};
            end
          end
        end
        RUN: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == '0) begin
            Res   <= it_res;
            flags <= {1'b0, 1'b0, it_v, 1'b0,
                      it_res[WIDTH-1], ~|it_res};
          end
        end
        default: ;
      endcase
    end
  end

  assign WR   = (state_q == DONE) && EN;
  assign done = WR;
  assign busy = (state_q != IDLE);

endmodule
